// File: rtl/axi_lite_bram_bridge.sv
// rtl/axi_lite_bram_bridge.sv - AXI4-Lite slave to single-port block-RAM bridge
// Single-beat reads/writes become one-cycle BRAM enable/byte-write cycles.
module axi_lite_bram_bridge #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [31:0]           s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_wrdata,
  input  logic [31:0]           bram_rddata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_RESP} state_t;

  state_t                 state;
  logic                   aw_held;
  logic                   w_held;
  logic                   last_wr;
  logic [ADDR_WIDTH-1:2]  awaddr_held;
  logic [31:0]            wdata_held;
  logic [3:0]             wstrb_held;
  logic [31:0]            rdata_q;
  logic                   bvalid_q;
  logic                   rvalid_q;
  logic                   wr_req;
  logic                   rd_req;
  logic                   rd_grant;
  logic                   wr_grant;
  logic                   unused_inputs;

  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  // Grants are qualified by !reset so a reset cycle can never enable the BRAM.
  always_comb begin
    wr_req   = aw_held && w_held;
    rd_req   = s_axi_arvalid;
    rd_grant = !reset && (state == IDLE) && rd_req && (!wr_req || last_wr);
    wr_grant = !reset && (state == IDLE) && wr_req && !(rd_req && last_wr);
  end

  assign s_axi_awready = !aw_held;
  assign s_axi_wready  = !w_held;
  assign s_axi_arready = rd_grant;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  assign bram_en     = rd_grant || wr_grant;
  assign bram_we     = wr_grant ? wstrb_held : 4'b0000;
  assign bram_addr   = rd_grant ? {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00}
                                : {awaddr_held, 2'b00};
  assign bram_wrdata = wdata_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      last_wr     <= 1'b0;
      awaddr_held <= '0;
      wdata_held  <= 32'h0;
      wstrb_held  <= 4'h0;
      rdata_q     <= 32'h0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      // Holding registers fill independently of the FSM; a grant needs both full.
      if (s_axi_awvalid && !aw_held) begin
        aw_held     <= 1'b1;
        awaddr_held <= s_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (s_axi_wvalid && !w_held) begin
        w_held     <= 1'b1;
        wdata_held <= s_axi_wdata;
        wstrb_held <= s_axi_wstrb;
      end

      case (state)
        IDLE: begin
          if (rd_grant) begin
            last_wr <= 1'b0;
            state   <= RD_WAIT;
          end else if (wr_grant) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            last_wr  <= 1'b1;
            bvalid_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        RD_WAIT: begin
          rdata_q  <= bram_rddata;
          rvalid_q <= 1'b1;
          state    <= RD_RESP;
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_bram_bridge.md
# axi_lite_bram_bridge

AXI4-Lite slave to single-port block-RAM bridge. It sits between one memory port of the `pipeline` core (`imem_axi_*` or `dmem_axi_*`) and one port of the dual-port `RAM`. It translates single-beat AXI4-Lite reads and writes into BRAM enable, byte-write-enable and address cycles. It is the in-house replacement for the vendor BRAM controller IP on both memory ports.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: byte-address width passed to the BRAM side.

Ports (`*_prot` inputs are accepted and ignored):
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `s_axi_awaddr` in 32, `s_axi_awprot` in 3, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in 32, `s_axi_arprot` in 3, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `bram_en`  out  1  BRAM port enable.
- `bram_we`  out  4  per-byte write enable.
- `bram_addr`  out  ADDR_WIDTH  byte address, bits [1:0] always 0.
- `bram_wrdata`  out  32  write data.
- `bram_rddata`  in  32  read data, valid 1 cycle after an enabled read.

## Operation
- **Write capture:**
  - AW and W are captured independently into holding registers with flags `aw_held` and `w_held`.
  - `s_axi_awready = !aw_held`; `s_axi_wready = !w_held`. These are registered flags, not combinational from valid.
  - Either channel may arrive first. Any gap between them is allowed.
- **FSM states:** IDLE, RD_WAIT, RD_RESP, WR_RESP.
- **IDLE:**
  - `wr_req = aw_held && w_held`; `rd_req = s_axi_arvalid`.
  - If both are requested, arbitration uses the `last_wr` flag: read wins if `last_wr` = 1, otherwise write wins. The flag resets to 0.
- **Read grant (IDLE):**
  - `s_axi_arready = 1` this cycle.
  - Same cycle: `bram_en = 1`, `bram_we = 0`, `bram_addr = {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00}`.
  - Then go to RD_WAIT and clear `last_wr`.
- **RD_WAIT:**
  - Register `bram_rddata` into `s_axi_rdata`.
  - Go to RD_RESP.
- **RD_RESP:**
  - `s_axi_rvalid = 1`. `s_axi_rdata` is held stable until `s_axi_rready`.
  - On handshake, go to IDLE.
- **Write grant (IDLE):**
  - Same cycle: `bram_en = 1`, `bram_we = wstrb_held`, `bram_addr` from `awaddr_held`, `bram_wrdata = wdata_held`.
  - Clear `aw_held` and `w_held`, set `last_wr`, go to WR_RESP.
- **WR_RESP:**
  - `s_axi_bvalid = 1`.
  - On `s_axi_bready`, go to IDLE.
  - New AW/W may be captured during WR_RESP and RD_* states, because the holding registers are free.
- **Responses:** `s_axi_bresp` and `s_axi_rresp` are always 2'b00 (OKAY).
- **Address rules:**
  - Address bits [1:0] are ignored.
  - Bits above `ADDR_WIDTH-1` are ignored, so the address wraps modulo 2^ADDR_WIDTH.
- **Unused BRAM outputs:** When no grant is active, `bram_en = 0`, `bram_we = 0`, and `bram_addr`/`bram_wrdata` are don't-care (they drive holding-register values).
- **`wstrb` = 0:** The write still completes with a B response. `bram_en = 1`, `bram_we = 0`.

## Timing
- **Reset values:**
  - `s_axi_awready = 1`, `s_axi_wready = 1`, `s_axi_arready = 0`.
  - `s_axi_bvalid = 0`, `s_axi_rvalid = 0`, `s_axi_rdata = 0`.
  - `bram_en = 0`, `bram_we = 0`.
  - State = IDLE; flags cleared.
- **Reset priority:** While `reset` = 1, `bram_en` and `bram_we` are forced to 0 combinationally, so no BRAM write occurs in a reset cycle.
- **Read latency:** AR handshake at cycle N gives `rvalid` at N+2. Peak read throughput is 1 per 3 cycles.
- **Write latency:**
  - Second of AW/W handshaked at cycle N: BRAM write at N+1, `bvalid` at N+2.
  - If both are already held in IDLE at cycle N: BRAM write at N, `bvalid` at N+1.
- **No combinational path from `*ready` inputs to `*valid` outputs:**
  - `bvalid`/`rvalid` fall the cycle after the handshake.
  - The next grant occurs at the earliest in the IDLE cycle that follows.
- **Reset mid-transaction:** The in-flight transaction is dropped, `bvalid`/`rvalid` deassert next cycle, and held AW/W are discarded.

## Test plan
- **Single write then read:** AW=0x0000_0010 and W=0xDEADBEEF with `wstrb`=0xF, `bready`=1 → `bram_we`=0xF at `bram_addr`=0x0010 one cycle after the handshake, `bvalid` one cycle later, `bresp`=0. AR=0x10 → `rdata`=0xDEADBEEF exactly 2 cycles after the AR handshake.
- **Byte strobes and unaligned address:** Write 0x11223344 with `wstrb`=0x5 to address 0x13 → `bram_we`=0x5 at `bram_addr`=0x10. Read-back over the earlier 0xDEADBEEF gives 0xDE22BE44.
- **W before AW:** Drive W 3 cycles before AW → `wready` goes 0 after the W capture. The BRAM write happens only after AW arrives, with the correct data.
- **Arbitration:** Write held and `arvalid` asserted in the same IDLE cycle, `last_wr`=0 → write granted first. The read is then granted on the next IDLE cycle. Repeat after a completed write → read wins.
- **Read backpressure:** `rready` held low for 4 cycles → `rvalid` stays 1, `rdata` is unchanged, `arready` stays 0. Completes the cycle after `rready` = 1.
- **Reset mid-operation:** Assert reset in RD_RESP, and separately in the BRAM-write cycle → `rvalid` is 0 next cycle, no `bram_we` pulse occurs, and `awready`/`wready` are 1 after reset.
